// File: rtl/ic_master_read_burst_param.sv
// Parametrised Avalon-MM burst read master.
// Reads a byte-length region in bursts of up to MAX_BURST words, streams every
// returned word into a downstream FIFO, and reports busy/done status.
module ic_master_read_burst_param #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int MAX_BURST        = 64,
    parameter int BURSTCOUNT_WIDTH = 8,
    parameter int FIFO_DEPTH       = 256,
    parameter int FIFO_USED_WIDTH  = 9,
    parameter int NUM_STALL        = 2
) (
    input  logic                        iClk,
    input  logic                        iReset,
    input  logic                        iStart,
    input  logic                        iAbort,
    input  logic [ADDR_WIDTH-1:0]       iStart_read_address,
    input  logic [31:0]                 iLength,
    input  logic [NUM_STALL-1:0]        iStall,
    input  logic [FIFO_USED_WIDTH-1:0]  iFF_used,
    input  logic                        iWait_request,
    input  logic                        iRead_data_valid,
    input  logic [DATA_WIDTH-1:0]       iRead_data,
    output logic                        oRead,
    output logic [ADDR_WIDTH-1:0]       oRead_address,
    output logic [BURSTCOUNT_WIDTH-1:0] oBurst_length,
    output logic                        oFF_write_request,
    output logic [DATA_WIDTH-1:0]       oWrite_data,
    output logic                        oBusy,
    output logic                        oDone
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        REQ   = 3'd2,
        DATA  = 3'd3,
        DONE  = 3'd4
    } stateType;

    stateType                    state;
    stateType                    stateNext;
    logic [31:0]                 remaining;
    logic [BURSTCOUNT_WIDTH-1:0] beatCnt;
    logic [BURSTCOUNT_WIDTH-1:0] curBurst;
    logic [BURSTCOUNT_WIDTH-1:0] burstSel;
    logic                        abortPend;
    logic                        fifoRoom;
    logic                        issue;
    logic                        accept;
    logic                        burstEnd;
    logic                        inFlight;
    logic [ADDR_WIDTH-1:0]       addrStep;
    logic [32:0]                 spaceNeeded;

    assign inFlight = (state == REQ) || (state == DATA);
    assign oBusy    = (state != IDLE);
    assign oDone    = (state == DONE);
    assign addrStep = ADDR_WIDTH'(curBurst) << BYTE_SHIFT;

    // Size of the next burst and whether the FIFO can absorb it plus the write still in flight.
    always_comb begin
        burstSel    = (remaining < 32'(MAX_BURST)) ? remaining[BURSTCOUNT_WIDTH-1:0]
                                                   : BURSTCOUNT_WIDTH'(MAX_BURST);
        spaceNeeded = 33'(iFF_used) + 33'(burstSel) + 33'd1;
        fifoRoom    = (spaceNeeded <= 33'(FIFO_DEPTH));
    end

    // State register.
    // NOTE: asynchronous reset lives in the sensitivity list so outputs clear mid-burst without a clock edge.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and single-cycle control strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        stateNext = state;
        issue     = 1'b0;
        accept    = 1'b0;
        burstEnd  = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    stateNext = CHECK;
                end
            end
            CHECK: begin
                if ((remaining == 32'd0) || abortPend || iAbort) begin
                    stateNext = DONE;
                end else if ((iStall == '0) && fifoRoom) begin
                    issue     = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (!iWait_request) begin
                    accept    = 1'b1;
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (beatCnt == curBurst) begin
                    burstEnd  = 1'b1;
                    stateNext = CHECK;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Command side: address, burst length, remaining words, beat counter and abort flag.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oRead         <= 1'b0;
            oRead_address <= '0;
            oBurst_length <= '0;
            remaining     <= '0;
            beatCnt       <= '0;
            curBurst      <= '0;
            abortPend     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if ((state == IDLE) && iStart) begin
                oRead_address <= iStart_read_address;
                remaining     <= iLength >> BYTE_SHIFT;
                abortPend     <= 1'b0;
            end else if ((state != IDLE) && iAbort) begin
                abortPend <= 1'b1;
            end

            if (issue) begin
                oRead         <= 1'b1;
                oBurst_length <= burstSel;
                curBurst      <= burstSel;
            end else if (accept) begin
                oRead <= 1'b0;
            end

            if (issue) begin
                beatCnt <= '0;
            end else if (inFlight && iRead_data_valid) begin
                beatCnt <= beatCnt + 1'b1;
            end

            if (burstEnd) begin
                oRead_address <= oRead_address + addrStep;
                remaining     <= remaining - 32'(curBurst);
            end else if (state == DONE) begin
                oRead_address <= '0;
            end
        end
    end

    // FIFO side: forward each valid beat of an active burst one cycle later.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oFF_write_request <= 1'b0;
            oWrite_data       <= '0;
        end else begin
            oFF_write_request <= inFlight && iRead_data_valid;
            if (inFlight && iRead_data_valid) begin
                oWrite_data <= iRead_data;
            end
        end
    end

endmodule
